// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// parameter defaults and stream framing constants.
package program_loader_pkg;

  localparam int unsigned DEFAULT_MAX_WORDS     = 256;
  localparam logic [31:0] DEFAULT_BASE_ADDR     = 32'h0000_0000;
  localparam int unsigned DEFAULT_RELEASE_DELAY = 4;

  // Bytes in the length header; data words use the same framing.
  localparam int unsigned HDR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects bytes MSB first into 32-bit words and flags the byte that
// completes a word, presenting the finished word alongside that strobe.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word
);

  // Only the three older bytes need storing; the fourth is the live input.
  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  assign word_done = byte_valid && (byte_cnt == 2'(HDR_BYTES - 1));
  assign word      = {shreg, byte_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shreg    <= word[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, big-endian program from a byte stream into
// instruction memory, holding the CPU in reset until the image is complete.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS     = DEFAULT_MAX_WORDS,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int unsigned RELEASE_DELAY = DEFAULT_RELEASE_DELAY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          load_done,
  output logic          load_err,
  output loader_state_t state_dbg
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  loader_state_t state, state_next;

  logic             byte_accept;
  logic             reload_take;
  logic             word_done;
  logic [31:0]      asm_word;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic             last_word;
  logic [7:0]       drain_cnt;

  // Handshake: a byte moves only when rx_valid && rx_ready in the same cycle;
  // rx_ready depends on state alone, so the source may hold rx_valid freely.
  assign rx_ready    = (state == ST_HDR) || (state == ST_DATA);
  assign byte_accept = rx_valid && rx_ready;
  assign reload_take = reload && ((state == ST_RUN) || (state == ST_ERR));
  assign last_word   = (word_idx == n_words - CNT_W'(1));
  assign state_dbg   = state;

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_take),
    .byte_valid (byte_accept),
    .byte_data  (rx_data),
    .word_done  (word_done),
    .word       (asm_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_HDR: begin
        if (word_done) begin
          if (asm_word > 32'(MAX_WORDS)) begin
            state_next = ST_ERR;
          end else if (asm_word == 32'd0) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_done && last_word) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == 8'(RELEASE_DELAY - 1)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_next = ST_HDR;
        end
      end
      default: state_next = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HDR;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      cpu_rst   <= (state_next != ST_RUN);
      load_done <= (state_next == ST_RUN);
      load_err  <= (state_next == ST_ERR);
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 8'd1 : 8'd0;
    end
  end

  // Write port registers: the strobe lands the cycle after the final byte,
  // and address/data hold their last values between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      n_words    <= '0;
      word_idx   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (reload_take) begin
        word_idx <= '0;
      end else if ((state == ST_HDR) && word_done) begin
        n_words  <= CNT_W'(asm_word);
        word_idx <= '0;
      end else if ((state == ST_DATA) && word_done) begin
        imem_we    <= 1'b1;
        imem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
        imem_wdata <= asm_word;
        word_idx   <= word_idx + CNT_W'(1);
      end
    end
  end

endmodule
